// File: rtl/uart_hamming_pkg.sv
// Shared definitions for the Hamming(7,4) UART receiver: receiver state
// encoding, codeword bit positions and the syndrome/correction helpers.
// The optional SECDED decode (macro UART_HAMMING_SECDED_EN) is selected in
// hamming74_correct; nothing in this package depends on it.
package uart_hamming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Codeword positions 1..7 live in frame bits [0..6] (bit = position - 1).
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D3 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D5 = 5;
    localparam int POS_D6 = 6;
    localparam int POS_D7 = 7;

    // Syndrome {p4, p2, p1}: the failing parity checks spell the bad position.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
        logic s1, s2, s4;
        s1 = cw[POS_P1-1] ^ cw[POS_D3-1] ^ cw[POS_D5-1] ^ cw[POS_D7-1];
        s2 = cw[POS_P2-1] ^ cw[POS_D3-1] ^ cw[POS_D6-1] ^ cw[POS_D7-1];
        s4 = cw[POS_P4-1] ^ cw[POS_D5-1] ^ cw[POS_D6-1] ^ cw[POS_D7-1];
        return {s4, s2, s1};
    endfunction

    // Flip the position named by the syndrome; a zero syndrome flips nothing.
    function automatic logic [6:0] hamming_flip(input logic [6:0] cw, input logic [2:0] syn);
        logic [6:0] fixed;
        fixed = cw;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        end
        return fixed;
    endfunction

    function automatic logic [3:0] hamming_nibble(input logic [6:0] cw);
        return {cw[POS_D7-1], cw[POS_D6-1], cw[POS_D5-1], cw[POS_D3-1]};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) corrector. With UART_HAMMING_SECDED_EN defined,
// codeword bit 7 is an overall even parity bit and double errors are flagged
// uncorrectable; otherwise bit 7 is ignored and any non-zero syndrome is fixed.
module hamming74_correct
    import uart_hamming_pkg::*;
(
    input  logic [7:0] codeword,
    output logic [3:0] nibble,
    output logic [2:0] syndrome,
    output logic       uncorrectable,
    output logic       corrected
);

`ifdef UART_HAMMING_SECDED_EN
    logic       parity_err;
    logic [6:0] fixed;

    // SECDED decode: parity mismatch means one flipped bit, match with a
    // non-zero syndrome means two.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        syndrome      = hamming_syndrome(codeword[6:0]);
        parity_err    = ^codeword;
        fixed         = codeword[6:0];
        uncorrectable = 1'b0;
        corrected     = 1'b0;
        if (parity_err) begin
            // Zero syndrome here means the parity bit itself flipped.
            fixed     = hamming_flip(codeword[6:0], syndrome);
            corrected = 1'b1;
        end else if (syndrome != 3'd0) begin
            uncorrectable = 1'b1;
        end
        nibble = hamming_nibble(fixed);
    end
`else
    logic       unused_parity;
    logic [6:0] fixed;

    assign unused_parity = codeword[7];

    // Plain SEC decode: every non-zero syndrome is a single-bit correction.
    always_comb begin
        syndrome      = hamming_syndrome(codeword[6:0]);
        fixed         = hamming_flip(codeword[6:0], syndrome);
        uncorrectable = 1'b0;
        corrected     = (syndrome != 3'd0);
        nibble        = hamming_nibble(fixed);
    end
`endif

endmodule

// File: rtl/uart_hamming_rx.sv
// UART receiver that decodes each byte as a Hamming(7,4) codeword and packs
// NUM_CODEWORDS nibbles into one output word with a valid/ready handshake.
// Optional SECDED decoding is enabled with macro UART_HAMMING_SECDED_EN.
module uart_hamming_rx
    import uart_hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int NUM_CODEWORDS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       rx,
    output logic [4*NUM_CODEWORDS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_err,
    output logic                       frame_err,
    output logic                       overrun,
    output logic [7:0]                 corr_count,
    output logic [1:0]                 state_out,
    output logic [2:0]                 syndrome_out
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (NUM_CODEWORDS > 1) ? $clog2(NUM_CODEWORDS) : 1;
    localparam int WORD_W = 4 * NUM_CODEWORDS;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CODEWORDS - 1);

    rx_state_t           state;
    logic                rx_meta, rx_sync, rx_prev;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift;
    logic [7:0]          cw_reg;
    logic                cw_valid;

    logic [3:0]          dec_nibble;
    logic [2:0]          dec_syndrome;
    logic                dec_uncorr;
    logic                dec_corrected;

    logic [IDX_W-1:0]    nib_idx;
    logic [WORD_W-1:0]   asm_data;
    logic [NUM_CODEWORDS-1:0] asm_err;
    logic                word_done;

    assign state_out = state;

    // Synchroniser, edge detect and receive FSM; a good frame leaves its byte in cw_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            cw_reg    <= '0;
            cw_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples values from before this edge.
            frame_err <= 1'b0;
            if (ena) begin
                rx_meta  <= rx;
                rx_sync  <= rx_meta;
                rx_prev  <= rx_sync;
                cw_valid <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (rx_prev && !rx_sync) begin
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (baud_cnt == HALF_LAST) begin
                            baud_cnt <= '0;
                            // A line already back high at mid-start was a glitch.
                            state    <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt <= '0;
                            shift    <= {rx_sync, shift[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt <= '0;
                            state    <= ST_IDLE;
                            if (rx_sync) begin
                                cw_reg   <= shift;
                                cw_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    hamming74_correct u_correct (
        .codeword      (cw_reg),
        .nibble        (dec_nibble),
        .syndrome      (dec_syndrome),
        .uncorrectable (dec_uncorr),
        .corrected     (dec_corrected)
    );

    // Registered decode: store the nibble in its slot and flag a completed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the assembler slots are cleared only for tidy debug views; a fresh word is guaranteed by nib_idx restarting at 0.
            asm_data     <= '0;
            asm_err      <= '0;
            nib_idx      <= '0;
            word_done    <= 1'b0;
            syndrome_out <= '0;
            corr_count   <= '0;
        end else if (ena) begin
            word_done <= 1'b0;
            if (cw_valid) begin
                asm_data[int'(nib_idx)*4 +: 4] <= dec_nibble;
                asm_err[nib_idx]               <= dec_uncorr;
                syndrome_out                   <= dec_syndrome;
                if (dec_corrected && (corr_count != 8'hFF)) begin
                    corr_count <= corr_count + 8'd1;
                end
                if (nib_idx == IDX_LAST) begin
                    nib_idx   <= '0;
                    word_done <= 1'b1;
                end else begin
                    nib_idx <= nib_idx + 1'b1;
                end
            end
        end
    end

    // Output register: load a completed word unless the consumer is stalled, else drop it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (ena) begin
                if (word_done && (!out_valid || out_ready)) begin
                    out_data  <= asm_data;
                    out_err   <= |asm_err;
                    out_valid <= 1'b1;
                end else begin
                    if (word_done) begin
                        overrun <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Self-checking bench for uart_hamming_rx (CLKS_PER_BIT=16, NUM_CODEWORDS=2).
// Expectations follow UART_HAMMING_SECDED_EN when the bench is built with it.
module tb_uart_hamming_rx;
    import uart_hamming_pkg::*;

    localparam int CPB = 16;
    localparam int NCW = 2;

    logic           clk = 1'b0;
    logic           rst, ena, rx, out_ready;
    logic [4*NCW-1:0] out_data;
    logic           out_valid, out_err, frame_err, overrun;
    logic [7:0]     corr_count;
    logic [1:0]     state_out;
    logic [2:0]     syndrome_out;

    always #5 clk = ~clk;

    uart_hamming_rx #(.CLKS_PER_BIT(CPB), .NUM_CODEWORDS(NCW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rx           (rx),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_err      (out_err),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .corr_count   (corr_count),
        .state_out    (state_out),
        .syndrome_out (syndrome_out)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
    } word_t;

    typedef struct {
        logic [7:0] f0;
        logic [7:0] f1;
        logic [2:0] syn0;
        logic [7:0] data;
        logic       err;
        int         corr;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    frame_err_seen = 0;
    int    overrun_seen = 0;
    word_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each word as it is handed over, count pulses.
    always @(negedge clk) begin
        word_t w;
        if (frame_err) frame_err_seen++;
        if (overrun) overrun_seen++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
                w = sb.pop_front();
                check("word_data", 32'(out_data), 32'(w.data));
                check("word_err", 32'(out_err), 32'(w.err));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic push_word(input logic [7:0] d, input logic e);
        word_t w;
        w.data = d;
        w.err  = e;
        sb.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Returns once the FSM has left STOP (observed the negedge after the stop sample).
    task automatic wait_stop_sample(output logic ok);
        int n;
        n = 0;
        while (state_out != ST_STOP && n < 400) begin @(negedge clk); n++; end
        n = 0;
        while (state_out == ST_STOP && n < 40) begin @(negedge clk); n++; end
        ok = (state_out == ST_IDLE);
    endtask

    task automatic measure_latency(output int lat);
        logic ok;
        int   n;
        wait_stop_sample(ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        lat = ok ? n : -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   exp_corr;
        int   lat;
        int   fe0, ov0;
        logic seen_start;
        logic ok;

        vecs[0] = '{8'h55, 8'hAA, 3'd0, 8'h4B, 1'b0, 0};
        vecs[1] = '{8'h54, 8'hAA, 3'd1, 8'h4B, 1'b0, 1};
`ifdef UART_HAMMING_SECDED_EN
        vecs[2] = '{8'h56, 8'hAA, 3'd3, 8'h4B, 1'b1, 0};
        vecs[4] = '{8'hD5, 8'hAA, 3'd0, 8'h4B, 1'b0, 1};
`else
        vecs[2] = '{8'h56, 8'hAA, 3'd3, 8'h4A, 1'b0, 1};
        vecs[4] = '{8'hD5, 8'hAA, 3'd0, 8'h4B, 1'b0, 0};
`endif
        vecs[3] = '{8'h15, 8'hAA, 3'd7, 8'h4B, 1'b0, 1};
        vecs[5] = '{8'h00, 8'hFF, 3'd0, 8'hF0, 1'b0, 0};
        vecs[6] = '{8'hFF, 8'h00, 3'd0, 8'h0F, 1'b0, 0};

        rst = 1'b1; ena = 1'b1; rx = 1'b1; out_ready = 1'b1;
        exp_corr = 0;
        tick(3);
        check("rst_state", 32'(state_out), 32'(ST_IDLE));
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_corr", 32'(corr_count), 32'd0);
        check("rst_syndrome", 32'(syndrome_out), 32'd0);
        check("rst_pulses", 32'({frame_err, overrun}), 32'd0);
        rst = 1'b0;
        tick(4);

        // out_valid rises exactly 2 cycles after the last stop sample.
        send_frame(8'h55, 1'b1);
        push_word(8'h4B, 1'b0);
        fork
            send_frame(8'hAA, 1'b1);
            measure_latency(lat);
        join
        check("valid_latency", 32'(lat), 32'd2);
        wait_drain("latency_drain");

        // Table-driven decode vectors.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].f0, 1'b1);
            check($sformatf("v%0d_syndrome", i), 32'(syndrome_out), 32'(vecs[i].syn0));
            push_word(vecs[i].data, vecs[i].err);
            send_frame(vecs[i].f1, 1'b1);
            wait_drain($sformatf("v%0d_drain", i));
            exp_corr += vecs[i].corr;
            check($sformatf("v%0d_corr", i), 32'(corr_count), 32'(exp_corr));
        end

        // Quarter-bit glitch: FSM enters START, then falls back to IDLE.
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        seen_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (state_out == ST_START) seen_start = 1'b1;
        end
        check("glitch_start", 32'(seen_start), 32'd1);
        check("glitch_idle", 32'(state_out), 32'(ST_IDLE));
        check("glitch_no_valid", 32'(out_valid), 32'd0);

        // Frame while disabled is ignored entirely.
        ena = 1'b0;
        send_frame(8'h55, 1'b1);
        ena = 1'b1;
        tick(4);
        check("ena_idle", 32'(state_out), 32'(ST_IDLE));
        check("ena_no_valid", 32'(out_valid), 32'd0);

        // Bad stop bit: one frame_err pulse, assembler untouched.
        fe0 = frame_err_seen;
        send_frame(8'h55, 1'b0);
        check("frame_err_pulses", 32'(frame_err_seen - fe0), 32'd1);
        push_word(8'h4B, 1'b0);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_drain("frame_err_drain");
        check("frame_err_corr", 32'(corr_count), 32'(exp_corr));

        // Stalled consumer: first word held, second dropped with one overrun.
        out_ready = 1'b0;
        push_word(8'h4B, 1'b0);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_data", 32'(out_data), 32'h4B);
        ov0 = overrun_seen;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        check("overrun_pulses", 32'(overrun_seen - ov0), 32'd1);
        check("overrun_data_held", 32'(out_data), 32'h4B);

        // Ready asserted in the very cycle the next word completes: load, no overrun.
        push_word(8'hF0, 1'b0);
        send_frame(8'h00, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_stop_sample(ok);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("stop_seen", 32'(ok), 32'd1);
        wait_drain("same_cycle_drain");
        check("no_extra_overrun", 32'(overrun_seen - ov0), 32'd1);

        // Reset during DATA of the second frame abandons the partial word.
        send_frame(8'h55, 1'b1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        check("pre_reset_state", 32'(state_out), 32'(ST_DATA));
        rst = 1'b1;
        tick(2);
        check("mid_rst_state", 32'(state_out), 32'(ST_IDLE));
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_err", 32'(out_err), 32'd0);
        check("mid_rst_corr", 32'(corr_count), 32'd0);
        check("mid_rst_syndrome", 32'(syndrome_out), 32'd0);
        check("mid_rst_pulses", 32'({frame_err, overrun}), 32'd0);
        rst = 1'b0;
        exp_corr = 0;
        tick(4);
        push_word(8'h0F, 1'b0);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        wait_drain("post_rst_drain");
        check("post_rst_corr", 32'(corr_count), 32'(exp_corr));

        tick(10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
